// File: rtl/cordic_rotator_if.sv
// cordic_rotator_if: operand/result bus and start/busy/done handshake of the CORDIC rotator.
interface cordic_rotator_if #(parameter int WORD_LENGTH = 16);
  logic clear;
  logic start;
  logic signed [WORD_LENGTH-1:0] x_in, y_in, z_in;
  logic signed [WORD_LENGTH-1:0] x_out, y_out;
  logic busy;
  logic done;
  modport master (output clear, start, x_in, y_in, z_in, input x_out, y_out, busy, done);
  modport slave (input clear, start, x_in, y_in, z_in, output x_out, y_out, busy, done);
endinterface

// File: rtl/cordic_rotator.sv
// cordic_rotator: iterative rotation-mode CORDIC, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a K-scaling stage so outputs keep the input magnitude.
module cordic_rotator #(
  parameter int WORD_LENGTH = 16,
  parameter int FRAC_BITS = 13,
  parameter int ITERATIONS = 14
) (
  input logic clk,
  input logic rst,
  cordic_rotator_if.slave bus
);
  localparam int xw = WORD_LENGTH + 2;
  localparam int zw = WORD_LENGTH + 1;
  localparam logic signed [zw-1:0] half_pi = zw'($rtoi(1.5707963267948966 * real'(1 << FRAC_BITS) + 0.5));
  localparam logic signed [xw-1:0] vmax = xw'((1 << (WORD_LENGTH - 1)) - 1);
  localparam logic signed [xw-1:0] vmin = ~vmax;
`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {st_idle, st_iter, st_comp, st_done} state_t;
  localparam state_t after_iter = st_comp;
`else
  typedef enum logic [1:0] {st_idle, st_iter, st_done} state_t;
  localparam state_t after_iter = st_done;
`endif
  state_t state;
  logic signed [xw-1:0] x, y, x_nxt, y_nxt, x0, y0, xi, yi;
  logic signed [zw-1:0] z, z_nxt, z0, zi;
  logic signed [zw-1:0] rom [16];
  logic [4:0] cnt;
  logic neg, hi, lo, last;
  function automatic logic signed [zw-1:0] atan_q(input int k);
    real r;
    case (k)
      0: r = 0.7853981633974483;
      1: r = 0.4636476090008061;
      2: r = 0.2449786631268641;
      3: r = 0.1243549945467614;
      4: r = 0.0624188099959574;
      5: r = 0.0312398334302683;
      6: r = 0.0156237286204768;
      7: r = 0.0078123410601011;
      8: r = 0.0039062301319670;
      9: r = 0.0019531225164788;
      10: r = 0.0009765621895593;
      11: r = 0.0004882812111949;
      12: r = 0.0002441406201494;
      13: r = 0.0001220703118937;
      14: r = 0.0000610351561742;
      default: r = 0.0000305175781155;
    endcase
    return zw'($rtoi(r * real'(1 << FRAC_BITS) + 0.5));
  endfunction
  function automatic logic signed [WORD_LENGTH-1:0] sat(input logic signed [xw-1:0] v);
    return v > vmax ? vmax[WORD_LENGTH-1:0] : v < vmin ? vmin[WORD_LENGTH-1:0] : v[WORD_LENGTH-1:0];
  endfunction
`ifdef CORDIC_GAIN_COMP_EN
  // K ~= 0.60725 as 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13
  function automatic logic signed [xw-1:0] gain(input logic signed [xw-1:0] v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) - (v >>> 13);
  endfunction
`endif
  for (genvar k = 0; k < 16; k++) begin : g_rom
    assign rom[k] = atan_q(k);
  end
  // Angles beyond +-pi/2 are folded in by an exact quarter turn before iterating
  always_comb begin
    xi = xw'(bus.x_in);
    yi = xw'(bus.y_in);
    zi = zw'(bus.z_in);
    hi = zi > half_pi;
    lo = zi < -half_pi;
    x0 = hi ? -yi : lo ? yi : xi;
    y0 = hi ? xi : lo ? -xi : yi;
    z0 = hi ? zi - half_pi : lo ? zi + half_pi : zi;
    neg = z[zw-1];
    x_nxt = neg ? x + (y >>> cnt) : x - (y >>> cnt);
    y_nxt = neg ? y - (x >>> cnt) : y + (x >>> cnt);
    z_nxt = neg ? z + rom[cnt[3:0]] : z - rom[cnt[3:0]];
    last = cnt == 5'(ITERATIONS - 1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= st_idle;
      x <= '0;
      y <= '0;
      z <= '0;
      cnt <= '0;
      bus.x_out <= '0;
      bus.y_out <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else if (bus.clear) begin
      state <= st_idle;
      x <= '0;
      y <= '0;
      z <= '0;
      cnt <= '0;
      bus.x_out <= '0;
      bus.y_out <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        st_idle: if (bus.start) begin
          x <= x0;
          y <= y0;
          z <= z0;
          cnt <= '0;
          bus.busy <= 1'b1;
          state <= st_iter;
        end
        st_iter: begin
          x <= x_nxt;
          y <= y_nxt;
          z <= z_nxt;
          cnt <= cnt + 5'd1;
          if (last) state <= after_iter;
        end
`ifdef CORDIC_GAIN_COMP_EN
        st_comp: begin
          x <= gain(x);
          y <= gain(y);
          state <= st_done;
        end
`endif
        st_done: begin
          bus.x_out <= sat(x);
          bus.y_out <= sat(y);
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state <= st_idle;
        end
        default: state <= st_idle;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_rotator.sv
// tb_cordic_rotator: directed vectors for cordic_rotator, scoreboard queue checked by a done monitor.
module tb_cordic_rotator;
  localparam int W = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = 16;
  localparam int AMP = 8192;
`else
  localparam int LAT = 15;
  localparam int AMP = 4974;
`endif
  typedef struct {string name; int x; int y; int tol; int acc;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int total = 0;
  int passed = 0;
  int ndone = 0;
  exp_t sb[$];
  exp_t got;
  cordic_rotator_if #(.WORD_LENGTH(W)) bus ();
  cordic_rotator #(.WORD_LENGTH(W), .FRAC_BITS(13), .ITERATIONS(14)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input bit ok, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d, want %0d", n, act, exp);
  endtask
  function automatic bit near(input int a, input int e, input int t);
    return a - e <= t && e - a <= t;
  endfunction
  always @(negedge clk) if (bus.done) begin
    ndone++;
    if (sb.size() == 0) chk("unexpected_done", 1'b0, 1, 0);
    else begin
      got = sb.pop_front();
      chk({got.name, "_x"}, near(int'(bus.x_out), got.x, got.tol), int'(bus.x_out), got.x);
      chk({got.name, "_y"}, near(int'(bus.y_out), got.y, got.tol), int'(bus.y_out), got.y);
      chk({got.name, "_lat"}, cyc - got.acc == LAT, cyc - got.acc, LAT);
    end
  end
  task automatic issue(input string n, input int x, input int y, input int z,
                       input int ex, input int ey, input int tol, input bit push);
    bus.x_in = W'(x);
    bus.y_in = W'(y);
    bus.z_in = W'(z);
    bus.start = 1'b1;
    if (push) sb.push_back('{name: n, x: ex, y: ey, tol: tol, acc: cyc + 1});
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic run(input string n, input int x, input int y, input int z,
                     input int ex, input int ey, input int tol);
    int nb = 0;
    int k = 0;
    issue(n, x, y, z, ex, ey, tol, 1'b1);
    while (!bus.done && k < 40) begin
      if (bus.busy) nb++;
      @(negedge clk);
      k++;
    end
    chk({n, "_done"}, bus.done == 1'b1, k, LAT);
    chk({n, "_busy"}, nb == LAT, nb, LAT);
  endtask
  task automatic wait_done(input string n);
    int k = 0;
    while (!bus.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({n, "_done"}, bus.done == 1'b1, k, LAT);
  endtask
  task automatic quiet(input string n);
    int m = ndone;
    repeat (LAT + 5) @(negedge clk);
    chk(n, ndone == m, ndone - m, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end
  initial begin
    bus.clear = 1'b0;
    bus.start = 1'b0;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.z_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_x_out", bus.x_out == '0, int'(bus.x_out), 0);
    chk("rst_y_out", bus.y_out == '0, int'(bus.y_out), 0);
    chk("rst_busy", bus.busy == 1'b0, int'(bus.busy), 0);
    chk("rst_done", bus.done == 1'b0, int'(bus.done), 0);
    rst = 1'b1;
    @(negedge clk);
    run("pi4", AMP, 0, 6434, 5793, 5793, 4);
    run("pi", AMP, 0, 25736, -8192, 0, 4);
    run("neg_pi", AMP, 0, -25736, -8192, 0, 4);
    run("m_half_pi", AMP, 0, -12868, 0, -8192, 4);
    run("zero", AMP, 0, 0, 8192, 0, 4);
`ifndef CORDIC_GAIN_COMP_EN
    run("sat_pos", 30000, 30000, 0, 32767, 32767, 0);
    run("sat_neg", -30000, -30000, 0, -32768, -32768, 0);
`endif
    @(negedge clk);
    issue("busy_start", AMP, 0, 6434, 5793, 5793, 4, 1'b1);
    repeat (4) @(negedge clk);
    issue("ignored", -AMP, AMP, 0, 0, 0, 0, 1'b0);
    wait_done("busy_start");
    @(negedge clk);
    quiet("single_done");
    issue("cleared", AMP, 0, 0, 0, 0, 0, 1'b0);
    repeat (5) @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("clr_busy", bus.busy == 1'b0, int'(bus.busy), 0);
    chk("clr_x_out", bus.x_out == '0, int'(bus.x_out), 0);
    chk("clr_y_out", bus.y_out == '0, int'(bus.y_out), 0);
    quiet("clear_no_done");
    run("after_clear", AMP, 0, 0, 8192, 0, 4);
    issue("reset", AMP, 0, 6434, 0, 0, 0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_x_out", bus.x_out == '0, int'(bus.x_out), 0);
    chk("arst_y_out", bus.y_out == '0, int'(bus.y_out), 0);
    chk("arst_busy", bus.busy == 1'b0, int'(bus.busy), 0);
    chk("arst_done", bus.done == 1'b0, int'(bus.done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    quiet("rst_no_done");
    run("after_rst", AMP, 0, -12868, 0, -8192, 4);
    @(negedge clk);
    chk("sb_empty", sb.size() == 0, sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
